// File: rtl/data_memory_bank.sv
// +--------------------------------------------------------------------------+
// | data_memory_bank: parametrised 1W/1R data store with zero-fill sequencer |
// | Optional: DATA_MEMORY_BANK_RD_BYPASS_EN (write-to-read byte forwarding)  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module data_memory_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                clr_req,
  output logic                busy,
  output logic                addr_err
);

  localparam int              NB        = DATA_W / 8;
  localparam int              CNT_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               addr_err_q, addr_err_d;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic               mem_we;
  logic [CNT_W-1:0]   mem_widx;
  logic [DATA_W-1:0]  mem_wdata;

  logic               wr_in_range;
  logic               rd_in_range;
  logic [CNT_W-1:0]   wr_idx;
  logic [CNT_W-1:0]   rd_idx;
  logic [DATA_W-1:0]  wr_merged;
  logic [DATA_W-1:0]  rd_word;

  // Full-width compare so high address bits can never alias into the array.
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
  assign wr_idx      = wr_addr[CNT_W-1:0];
  assign rd_idx      = rd_addr[CNT_W-1:0];

  always_comb begin
    wr_merged = mem_q[wr_idx];
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) begin
        wr_merged[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

`ifdef DATA_MEMORY_BANK_RD_BYPASS_EN
  always_comb begin
    rd_word = mem_q[rd_idx];
    if (wr_en && wr_in_range && (wr_addr == rd_addr)) begin
      rd_word = wr_merged;
    end
  end
`else
  assign rd_word = mem_q[rd_idx];
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;
    mem_we     = 1'b0;
    mem_widx   = wr_idx;
    mem_wdata  = wr_merged;

    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_widx  = cnt_q;
      mem_wdata = '0;
      if (cnt_q == LAST_IDX) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      mem_we = wr_en && wr_in_range;
      if (rd_en) begin
        rd_valid_d = 1'b1;
        rd_data_d  = rd_in_range ? rd_word : '0;
      end
      addr_err_d = (wr_en && !wr_in_range) || (rd_en && !rd_in_range);
      // A same-cycle write still lands; the fill then zeroes it.
      if (clr_req) begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule

`default_nettype wire

// File: doc/data_memory_bank.md
Name: data_memory_bank

Overview:
- Parametrised single-clock data memory with one write port and one read port, plus an internal clear sequencer.
- Successor to the fixed 32x8 data memory in the APB/LIN top. Adds configurable width and depth, byte-enabled writes, a registered read with valid flag, out-of-range address detection, and an auto/explicit zero-fill state machine.
- Sits behind the APB register decode as the LIN frame/data buffer store.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 8, number of words; need not be a power of two.
- ADDR_W, 32, width of the wr_addr and rd_addr ports.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request for this cycle.
- wr_addr  input  ADDR_W  write word address.
- wr_data  input  DATA_W  write data.
- wr_be  input  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  input  1  read request for this cycle.
- rd_addr  input  ADDR_W  read word address.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  one-cycle pulse: rd_data was updated by a read.
- clr_req  input  1  request a zero-fill of the whole array.
- busy  output  1  clear sequencer active; user accesses are ignored.
- addr_err  output  1  one-cycle pulse on an out-of-range access.

Behaviour:
- Reset (reset=0, asynchronous): rd_data=0, rd_valid=0, addr_err=0, busy=1, FSM=CLEAR, clear counter=0. Array contents are undefined until the clear completes.
- FSM state CLEAR:
  - Each rising edge writes mem[cnt]=0 and increments cnt.
  - When cnt==DEPTH-1, that edge also moves the FSM to IDLE and sets cnt=0.
  - busy=1 throughout. Exactly DEPTH edges from entry to busy=0.
- FSM state IDLE: busy=0. clr_req=1 moves the FSM to CLEAR on the next edge.
- clr_req while in CLEAR: ignored; the counter is not restarted.
- Reset asserted mid-clear: sequencer restarts from cnt=0 after reset release.
- User accesses while busy=1:
  - wr_en and rd_en are ignored entirely: no array write, rd_valid=0, addr_err=0.
  - rd_data holds its value.
- Write (IDLE, wr_en=1):
  - If wr_addr < DEPTH, for each i with wr_be[i]=1, byte i of mem[wr_addr] takes byte i of wr_data on the edge. Other bytes are unchanged.
  - wr_be=0 is a legal no-op.
- Read (IDLE, rd_en=1), one-cycle latency:
  - Request sampled at edge N; rd_data and rd_valid=1 appear after edge N.
  - rd_valid returns to 0 after edge N+1 unless rd_en is held.
  - Back-to-back reads are supported: one result per cycle.
  - rd_data holds its last value when no read occurs.
- Out of range (address >= DEPTH, full ADDR_W compare):
  - Write is dropped.
  - Read returns rd_data=0 with rd_valid=1.
  - addr_err=1 for one cycle, aligned with rd_valid timing (the cycle after the request).
  - Both ports out of range in the same cycle give a single addr_err pulse.
- Same-cycle write and read to the same in-range address: rd_data returns the pre-write contents (read-before-write), unless RD_BYPASS_EN is defined.
- Same-cycle wr_en and clr_req in IDLE: the write is performed, then the FSM enters CLEAR and the entry is zeroed during the fill.

Optional Feature:
- Macro: DATA_MEMORY_BANK_RD_BYPASS_EN.
- Defined: on a same-cycle in-range write and read to the same address, rd_data returns a byte-merged value.
  - Byte i is wr_data when wr_be[i]=1, otherwise the old mem byte.
  - No extra latency.
- Undefined: read-before-write as described above; no forwarding logic is synthesised.

Test Plan:
- Reset, then clear (DEPTH=8, DATA_W=32):
  - Hold reset=0, release it.
  - Required: busy=1 for exactly 8 edges, then 0.
  - Read addresses 0..7 → each returns 0x00000000 with rd_valid=1, one cycle after request.
- Byte-enable write:
  - Write 0xAABBCCDD to addr 3 with be=4'b1111.
  - Then write 0x11223344 to addr 3 with be=4'b0101.
  - Read addr 3 → 0xAA22CC44.
- Out-of-range access:
  - Write addr 8, then read addr 8 → addr_err pulses each time; read gives rd_data=0 with rd_valid=1.
  - Read addr 0 → unchanged.
  - Repeat with addr 0xFFFFFFFF → same result.
- Read-during-write to addr 5 (old value 0x12345678, new 0xCAFEF00D, be=4'b1111):
  - Without macro → rd_data=0x12345678.
  - With DATA_MEMORY_BANK_RD_BYPASS_EN → 0xCAFEF00D.
  - Either way, a following read → 0xCAFEF00D.
- clr_req handling:
  - Fill all entries with 0x5A5A5A5A, pulse clr_req → busy high for 8 cycles.
  - Writes/reads issued during busy → no rd_valid, no array change.
  - All entries read 0 afterwards.
  - A second clr_req mid-clear does not extend busy beyond 8 cycles.
- Reset mid-clear:
  - Assert reset at clear cycle 4 → rd_data=0, rd_valid=0, busy=1 immediately.
  - After release → busy for a full 8 cycles; all entries 0.
